// File: rtl/event_grid_accumulator.sv
// Accumulates downsampled DVS events into a signed polarity map held in one
// synchronous-read RAM. Supports periodic decay toward zero and raster readout.
module event_grid_accumulator #(
  parameter int unsigned GRID_BITS    = 4,
  parameter int unsigned CNT_BITS     = 8,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned DECAY_PERIOD = 65536,
  parameter int unsigned DECAY_SHIFT  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [GRID_BITS-1:0]   x_in,
  input  logic [GRID_BITS-1:0]   y_in,
  input  logic                   polarity_in,
  input  logic [15:0]            timestamp_in,
  input  logic                   event_valid_in,
  input  logic                   rd_start,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [2*GRID_BITS-1:0] rd_addr,
  output logic [CNT_BITS-1:0]    rd_data,
  output logic                   rd_last,
  output logic                   busy,
  output logic [15:0]            last_ts,
  output logic [15:0]            drop_count
);

  localparam int unsigned AddrW    = 2 * GRID_BITS;
  localparam int unsigned NumCells = 1 << AddrW;
  localparam int unsigned TsW      = 16;
  localparam int unsigned EvtW     = AddrW + 1 + TsW;
  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned DcntW    = $clog2(DECAY_PERIOD);

  localparam logic [PtrW:0]          FifoFull = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [DcntW-1:0]       DcntLast = DcntW'(DECAY_PERIOD - 1);
  localparam logic [CNT_BITS-1:0]    CntMax   = {1'b0, {(CNT_BITS - 1){1'b1}}};
  localparam logic [CNT_BITS-1:0]    CntMin   = {1'b1, {(CNT_BITS - 1){1'b0}}};
  localparam logic [CNT_BITS-1:0]    CntOne   = CNT_BITS'(1);

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StAccumRd,
    StAccumWr,
    StDecayRd,
    StDecayWr,
    StRdReq,
    StRdOut
  } state_e;

  state_e state_q, state_d;

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [EvtW-1:0]  fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    fifo_cnt_q, fifo_cnt_d;
  logic             fifo_full, fifo_empty;
  logic             push, pop;
  logic [EvtW-1:0]  fifo_head;
  logic [AddrW-1:0] head_addr;
  logic             head_pol;
  logic [TsW-1:0]   head_ts;
  logic [15:0]      drop_q, drop_d;

  assign fifo_full  = (fifo_cnt_q == FifoFull);
  assign fifo_empty = (fifo_cnt_q == '0);
  // Full is judged on the registered count, so a same-cycle pop never rescues a push.
  assign push       = event_valid_in && !fifo_full;
  assign fifo_head  = fifo_mem_q[rd_ptr_q];
  assign head_addr  = fifo_head[EvtW-1 -: AddrW];
  assign head_pol   = fifo_head[TsW];
  assign head_ts    = fifo_head[TsW-1:0];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    drop_d     = drop_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    if (event_valid_in && fifo_full && (drop_q != 16'hFFFF)) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {y_in, x_in, polarity_in, timestamp_in};
  end

  // ---------------------------------------------------------------------------
  // Decay timer and pending requests
  // ---------------------------------------------------------------------------
  logic [DcntW-1:0] dcnt_q, dcnt_d;
  logic             dcnt_wrap;
  logic             decay_pend_q, decay_pend_d;
  logic             rd_pend_q, rd_pend_d;
  logic             take_arb;
  state_e           arb_state;

  assign dcnt_wrap = (dcnt_q == DcntLast);

  always_comb begin
    arb_state = StIdle;
    if (rd_pend_q)         arb_state = StRdReq;
    else if (decay_pend_q) arb_state = StDecayRd;
    else if (!fifo_empty)  arb_state = StAccumRd;
  end

  always_comb begin
    dcnt_d       = dcnt_wrap ? '0 : dcnt_q + 1'b1;
    // A new request arriving on the accept cycle is kept rather than lost.
    rd_pend_d    = rd_start  || (rd_pend_q && !(take_arb && arb_state == StRdReq));
    decay_pend_d = dcnt_wrap || (decay_pend_q && !(take_arb && arb_state == StDecayRd));
  end

  // ---------------------------------------------------------------------------
  // Cell RAM
  // ---------------------------------------------------------------------------
  logic [CNT_BITS-1:0]        cell_mem [NumCells];
  logic signed [CNT_BITS-1:0] ram_rdata_q;
  logic                       ram_re, ram_we;
  logic [AddrW-1:0]           ram_addr;
  logic [CNT_BITS-1:0]        ram_wdata;

  always_ff @(posedge clk) begin
    if (ram_we) cell_mem[ram_addr] <= ram_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_rdata_q <= '0;
    end else if (ram_re) begin
      ram_rdata_q <= cell_mem[ram_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Cell update arithmetic
  // ---------------------------------------------------------------------------
  logic                       acc_pol_q, acc_pol_d;
  logic [TsW-1:0]             acc_ts_q, acc_ts_d;
  logic [CNT_BITS-1:0]        acc_val;
  logic signed [CNT_BITS-1:0] dec_step;
  logic [CNT_BITS-1:0]        dec_val;

  always_comb begin
    if (acc_pol_q) begin
      acc_val = (ram_rdata_q == CntMax) ? ram_rdata_q : ram_rdata_q + CntOne;
    end else begin
      acc_val = (ram_rdata_q == CntMin) ? ram_rdata_q : ram_rdata_q - CntOne;
    end
  end

  always_comb begin
    dec_step = ram_rdata_q >>> DECAY_SHIFT;
    // Small magnitudes shift to zero (or -1 stays -1); force a unit step so they still decay.
    if (dec_step != '0)                dec_val = ram_rdata_q - dec_step;
    else if (ram_rdata_q[CNT_BITS-1])  dec_val = ram_rdata_q + CntOne;
    else if (ram_rdata_q != '0)        dec_val = ram_rdata_q - CntOne;
    else                               dec_val = '0;
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  logic [AddrW-1:0] addr_q, addr_d;
  logic [TsW-1:0]   last_ts_q, last_ts_d;
  logic             rd_valid_q, rd_valid_d;
  logic [AddrW-1:0] rd_addr_q, rd_addr_d;
  logic             rd_last_q, rd_last_d;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    acc_pol_d  = acc_pol_q;
    acc_ts_d   = acc_ts_q;
    last_ts_d  = last_ts_q;
    rd_valid_d = rd_valid_q;
    rd_addr_d  = rd_addr_q;
    rd_last_d  = rd_last_q;
    ram_re     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = addr_q;
    ram_wdata  = '0;
    pop        = 1'b0;
    take_arb   = 1'b0;

    case (state_q)
      StInit: begin
        ram_we = 1'b1;
        if (addr_q == '1) begin
          addr_d  = '0;
          state_d = StIdle;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      StIdle: take_arb = 1'b1;
      StAccumRd: begin
        pop       = 1'b1;
        ram_re    = 1'b1;
        ram_addr  = head_addr;
        addr_d    = head_addr;
        acc_pol_d = head_pol;
        acc_ts_d  = head_ts;
        state_d   = StAccumWr;
      end
      StAccumWr: begin
        // Arbitrate here directly so sustained events run at one per two clocks.
        ram_we    = 1'b1;
        ram_wdata = acc_val;
        last_ts_d = acc_ts_q;
        take_arb  = 1'b1;
      end
      StDecayRd: begin
        ram_re  = 1'b1;
        state_d = StDecayWr;
      end
      StDecayWr: begin
        ram_we    = 1'b1;
        ram_wdata = dec_val;
        if (addr_q == '1) begin
          addr_d  = '0;
          state_d = StIdle;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = StDecayRd;
        end
      end
      StRdReq: begin
        ram_re     = 1'b1;
        rd_valid_d = 1'b1;
        rd_addr_d  = addr_q;
        rd_last_d  = (addr_q == '1);
        state_d    = StRdOut;
      end
      StRdOut: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          if (addr_q == '1) begin
            addr_d  = '0;
            state_d = StIdle;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = StRdReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (take_arb) begin
      state_d = arb_state;
      if (arb_state == StRdReq || arb_state == StDecayRd) addr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StInit;
      addr_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      drop_q       <= '0;
      dcnt_q       <= '0;
      decay_pend_q <= 1'b0;
      rd_pend_q    <= 1'b0;
      acc_pol_q    <= 1'b0;
      acc_ts_q     <= '0;
      last_ts_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_addr_q    <= '0;
      rd_last_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      drop_q       <= drop_d;
      dcnt_q       <= dcnt_d;
      decay_pend_q <= decay_pend_d;
      rd_pend_q    <= rd_pend_d;
      acc_pol_q    <= acc_pol_d;
      acc_ts_q     <= acc_ts_d;
      last_ts_q    <= last_ts_d;
      rd_valid_q   <= rd_valid_d;
      rd_addr_q    <= rd_addr_d;
      rd_last_q    <= rd_last_d;
    end
  end

  // The RAM output register only changes on a read, so it stays stable while stalled.
  assign rd_data    = ram_rdata_q;
  assign rd_valid   = rd_valid_q;
  assign rd_addr    = rd_addr_q;
  assign rd_last    = rd_last_q;
  assign busy       = (state_q != StIdle);
  assign last_ts    = last_ts_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_event_grid_accumulator.sv
// Randomized bench for event_grid_accumulator: two instances (slow and fast decay)
// checked against an array model of the polarity map.
module tb_event_grid_accumulator;
  localparam int N = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_a, rst_b, sel;
  logic [3:0]  x_i, y_i;
  logic        pol_i, ev_i, start_i, ready_i;
  logic [15:0] ts_i;

  logic a_rd_valid, a_rd_last, a_busy, b_rd_valid, b_rd_last, b_busy;
  logic [7:0]  a_rd_addr, a_rd_data, b_rd_addr, b_rd_data;
  logic [15:0] a_last_ts, a_drop, b_last_ts, b_drop;

  event_grid_accumulator #(.GRID_BITS(4), .CNT_BITS(8), .FIFO_DEPTH(8),
    .DECAY_PERIOD(65536), .DECAY_SHIFT(2)) u_dut_a (
    .clk(clk), .rst(rst_a), .x_in(x_i), .y_in(y_i), .polarity_in(pol_i),
    .timestamp_in(ts_i), .event_valid_in(ev_i & ~sel), .rd_start(start_i & ~sel),
    .rd_valid(a_rd_valid), .rd_ready(ready_i & ~sel), .rd_addr(a_rd_addr),
    .rd_data(a_rd_data), .rd_last(a_rd_last), .busy(a_busy), .last_ts(a_last_ts),
    .drop_count(a_drop));

  event_grid_accumulator #(.GRID_BITS(4), .CNT_BITS(8), .FIFO_DEPTH(8),
    .DECAY_PERIOD(1024), .DECAY_SHIFT(2)) u_dut_b (
    .clk(clk), .rst(rst_b), .x_in(x_i), .y_in(y_i), .polarity_in(pol_i),
    .timestamp_in(ts_i), .event_valid_in(ev_i & sel), .rd_start(start_i & sel),
    .rd_valid(b_rd_valid), .rd_ready(ready_i & sel), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .rd_last(b_rd_last), .busy(b_busy), .last_ts(b_last_ts),
    .drop_count(b_drop));

  logic        rd_valid_m, rd_last_m, busy_m;
  logic [7:0]  rd_addr_m, rd_data_m;
  logic [15:0] last_ts_m, drop_m;
  assign rd_valid_m = sel ? b_rd_valid : a_rd_valid;
  assign rd_last_m  = sel ? b_rd_last  : a_rd_last;
  assign busy_m     = sel ? b_busy     : a_busy;
  assign rd_addr_m  = sel ? b_rd_addr  : a_rd_addr;
  assign rd_data_m  = sel ? b_rd_data  : a_rd_data;
  assign last_ts_m  = sel ? b_last_ts  : a_last_ts;
  assign drop_m     = sel ? b_drop     : a_drop;

  int checks = 0;
  int passed = 0;
  int model_a [N];
  int model_b [N];
  int cap_data [2][N];
  int cap_cnt [2][N];
  int cap_n, cap_hold_err, cap_last_err, cap_order_err;
  bit cap_timeout;
  logic cap_valid_after;
  logic [15:0] last_sent_ts;

  function automatic int apply_evt(input int v, input bit p);
    if (p) return (v < 127) ? v + 1 : 127;
    return (v > -128) ? v - 1 : -128;
  endfunction

  function automatic int decay_model(input int v);
    int d;
    d = (v >= 0) ? v / 4 : -((-v + 3) / 4);  // floor(v / 4)
    if (d != 0) return v - d;
    if (v > 0) return v - 1;
    if (v < 0) return v + 1;
    return 0;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_event(input int a, input bit p, input logic [15:0] t, input bit apply);
    x_i = 4'(a); y_i = 4'(a >> 4); pol_i = p; ts_i = t; ev_i = 1'b1;
    tick(1);
    ev_i = 1'b0;
    if (apply) begin
      last_sent_ts = t;
      if (sel) model_b[a] = apply_evt(model_b[a], p);
      else     model_a[a] = apply_evt(model_a[a], p);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (busy_m === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) tick(1);
  endtask

  // Requests a readout and records every handshake plus protocol violations.
  task automatic capture(input int nread, input bit toggle, input int start_at);
    bit r, stall;
    logic [7:0] p_addr, p_data;
    int cycles, ro, ea;
    cap_n = 0; cap_hold_err = 0; cap_last_err = 0; cap_order_err = 0; cap_timeout = 0;
    for (int k = 0; k < 2; k++) for (int a = 0; a < N; a++) begin
      cap_cnt[k][a] = 0; cap_data[k][a] = 0;
    end
    r = 1'b0; stall = 1'b0; cycles = 0; p_addr = '0; p_data = '0;
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    while (cap_n < nread) begin
      if (cycles > nread * 12) begin
        cap_timeout = 1'b1;
        break;
      end
      if (stall && (rd_valid_m !== 1'b1 || rd_addr_m !== p_addr || rd_data_m !== p_data))
        cap_hold_err++;
      r = toggle ? ~r : 1'b1;
      ready_i = r;
      stall = 1'b0;
      if (rd_valid_m === 1'b1) begin
        if (r) begin
          ro = cap_n / N;
          ea = cap_n % N;
          if (int'(rd_addr_m) != ea) cap_order_err++;
          if (rd_last_m !== (rd_addr_m == 8'hFF)) cap_last_err++;
          cap_data[ro][rd_addr_m] = int'($signed(rd_data_m));
          cap_cnt[ro][rd_addr_m]++;
          cap_n++;
          if (cap_n == start_at) start_i = 1'b1;
        end else begin
          stall = 1'b1; p_addr = rd_addr_m; p_data = rd_data_m;
        end
      end
      tick(1);
      start_i = 1'b0;
      cycles++;
    end
    ready_i = 1'b0;
    cap_valid_after = rd_valid_m;
  endtask

  task automatic test_reset();
    int n, bad;
    sel = 1'b0; rst_a = 1'b1;
    tick(2);
    checks++;
    if (busy_m !== 1'b1 || rd_valid_m !== 1'b0 || rd_last_m !== 1'b0) begin
      $display("FAIL reset_ctrl got busy=%b valid=%b last=%b exp 1 0 0", busy_m, rd_valid_m,
               rd_last_m);
    end else passed++;
    checks++;
    if (rd_addr_m !== 8'h00 || rd_data_m !== 8'h00) begin
      $display("FAIL reset_data got addr=%h data=%h exp 00 00", rd_addr_m, rd_data_m);
    end else passed++;
    checks++;
    if (last_ts_m !== 16'h0 || drop_m !== 16'h0) begin
      $display("FAIL reset_stats got last_ts=%h drop=%h exp 0 0", last_ts_m, drop_m);
    end else passed++;
    rst_a = 1'b0;
    n = 0;
    while (n < 400) begin
      tick(1);
      n++;
      if (busy_m !== 1'b1) break;
    end
    checks++;
    if (n != 256) $display("FAIL init_length got=%0d exp=256", n);
    else passed++;
    bad = 0;
    for (int i = n; i < 300; i++) begin
      tick(1);
      if (busy_m !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL idle_after_init got busy_cycles=%0d exp=0", bad);
    else passed++;
    capture(256, 1'b0, -1);
    checks++;
    if (cap_timeout || cap_order_err != 0 || cap_last_err != 0 || cap_valid_after !== 1'b0)
      $display("FAIL zero_readout_proto got timeout=%0d order=%0d last=%0d vafter=%b exp 0 0 0 0",
               cap_timeout, cap_order_err, cap_last_err, cap_valid_after);
    else passed++;
    for (int a = 0; a < N; a++) begin
      checks++;
      if (cap_data[0][a] != model_a[a] || cap_cnt[0][a] != 1)
        $display("FAIL zero_readout addr=%0d got=%0d cnt=%0d exp=%0d", a, cap_data[0][a],
                 cap_cnt[0][a], model_a[a]);
      else passed++;
    end
  endtask

  task automatic test_single_cell();
    bit ok;
    for (int i = 0; i < 5; i++) begin
      send_event(8'h23, 1'b1, 16'($urandom), 1'b1);
      tick(3);
    end
    wait_idle(ok);
    checks++;
    if (!ok || last_ts_m !== last_sent_ts)
      $display("FAIL single_last_ts got ok=%0d ts=%h exp ts=%h", ok, last_ts_m, last_sent_ts);
    else passed++;
    capture(256, 1'b0, -1);
    checks++;
    if (cap_timeout || cap_data[0][8'h23] != 5)
      $display("FAIL single_cell_0x23 got=%0d timeout=%0d exp=5", cap_data[0][8'h23], cap_timeout);
    else passed++;
    for (int a = 0; a < N; a++) begin
      checks++;
      if (cap_data[0][a] != model_a[a] || cap_cnt[0][a] != 1)
        $display("FAIL single_map addr=%0d got=%0d cnt=%0d exp=%0d", a, cap_data[0][a],
                 cap_cnt[0][a], model_a[a]);
      else passed++;
    end
  endtask

  task automatic test_saturation();
    int p, q;
    bit ok;
    p = $urandom_range(0, N - 1);
    q = (p + $urandom_range(1, N - 1)) % N;
    for (int i = 0; i < 200; i++) begin
      send_event(p, 1'b1, 16'($urandom), 1'b1);
      tick(2);
    end
    for (int i = 0; i < 300; i++) begin
      send_event(q, 1'b0, 16'($urandom), 1'b1);
      tick(2);
    end
    wait_idle(ok);
    capture(256, 1'b0, -1);
    checks++;
    if (!ok || cap_timeout || cap_data[0][p] != 127 || cap_data[0][q] != -128)
      $display("FAIL saturation got p=%0d q=%0d exp 127 -128", cap_data[0][p], cap_data[0][q]);
    else passed++;
    for (int a = 0; a < N; a++) begin
      checks++;
      if (cap_data[0][a] != model_a[a] || cap_cnt[0][a] != 1)
        $display("FAIL sat_map addr=%0d got=%0d cnt=%0d exp=%0d", a, cap_data[0][a],
                 cap_cnt[0][a], model_a[a]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int c;
    bit ok;
    for (int rep = 0; rep < 4; rep++) begin
      c = $urandom_range(0, N - 1);
      for (int i = 0; i < 8; i++) send_event(c, 1'($urandom), 16'($urandom), 1'b1);
      tick(25);
    end
    wait_idle(ok);
    checks++;
    if (!ok || drop_m !== 16'h0 || last_ts_m !== last_sent_ts)
      $display("FAIL b2b_stats got ok=%0d drop=%0d ts=%h exp drop=0 ts=%h", ok, drop_m,
               last_ts_m, last_sent_ts);
    else passed++;
    capture(256, 1'b0, -1);
    for (int a = 0; a < N; a++) begin
      checks++;
      if (cap_data[0][a] != model_a[a] || cap_cnt[0][a] != 1)
        $display("FAIL b2b_map addr=%0d got=%0d cnt=%0d exp=%0d", a, cap_data[0][a],
                 cap_cnt[0][a], model_a[a]);
      else passed++;
    end
  endtask

  task automatic test_random_events();
    bit ok;
    for (int i = 0; i < 150; i++) begin
      if (i % 30 == 29) begin
        for (int j = 0; j < 6; j++)
          send_event($urandom_range(0, N - 1), 1'($urandom), 16'($urandom), 1'b1);
        tick(20);
      end else begin
        send_event($urandom_range(0, N - 1), 1'($urandom), 16'($urandom), 1'b1);
        tick($urandom_range(1, 4));
      end
    end
    wait_idle(ok);
    checks++;
    if (!ok || drop_m !== 16'h0 || last_ts_m !== last_sent_ts)
      $display("FAIL random_stats got ok=%0d drop=%0d ts=%h exp drop=0 ts=%h", ok, drop_m,
               last_ts_m, last_sent_ts);
    else passed++;
    capture(256, 1'b0, -1);
    for (int a = 0; a < N; a++) begin
      checks++;
      if (cap_data[0][a] != model_a[a] || cap_cnt[0][a] != 1)
        $display("FAIL random_map addr=%0d got=%0d cnt=%0d exp=%0d", a, cap_data[0][a],
                 cap_cnt[0][a], model_a[a]);
      else passed++;
    end
  endtask

  task automatic test_readout_stall();
    capture(512, 1'b1, 100);
    checks++;
    if (cap_timeout || cap_hold_err != 0 || cap_order_err != 0 || cap_last_err != 0)
      $display("FAIL stall_proto got timeout=%0d hold=%0d order=%0d last=%0d exp 0 0 0 0",
               cap_timeout, cap_hold_err, cap_order_err, cap_last_err);
    else passed++;
    checks++;
    if (cap_valid_after !== 1'b0) $display("FAIL stall_valid_after got=%b exp=0", cap_valid_after);
    else passed++;
    for (int k = 0; k < 2; k++) for (int a = 0; a < N; a++) begin
      checks++;
      if (cap_data[k][a] != model_a[a] || cap_cnt[k][a] != 1)
        $display("FAIL stall_map pass=%0d addr=%0d got=%0d cnt=%0d exp=%0d", k, a,
                 cap_data[k][a], cap_cnt[k][a], model_a[a]);
      else passed++;
    end
    tick(10);
    checks++;
    if (rd_valid_m !== 1'b0 || busy_m !== 1'b0)
      $display("FAIL stall_no_third got valid=%b busy=%b exp 0 0", rd_valid_m, busy_m);
    else passed++;
  endtask

  task automatic test_decay_values();
    int t0, base, a0, a1, a2, a3;
    bit ok;
    sel = 1'b1; rst_b = 1'b1;
    tick(2);
    rst_b = 1'b0; t0 = cyc;
    for (int a = 0; a < N; a++) model_b[a] = 0;
    wait_idle(ok);
    base = $urandom_range(0, N - 1);
    a0 = base; a1 = (base + 17) % N; a2 = (base + 40) % N; a3 = (base + 99) % N;
    for (int i = 0; i < 100; i++) begin send_event(a0, 1'b1, 16'($urandom), 1'b1); tick(2); end
    send_event(a1, 1'b1, 16'($urandom), 1'b1); tick(2);
    send_event(a2, 1'b0, 16'($urandom), 1'b1); tick(2);
    for (int i = 0; i < 8; i++) begin send_event(a3, 1'b0, 16'($urandom), 1'b1); tick(2); end
    for (int a = 0; a < N; a++) model_b[a] = decay_model(model_b[a]);
    wait_cycle(t0 + 1700);
    wait_idle(ok);
    capture(256, 1'b0, -1);
    checks++;
    if (!ok || cap_timeout || cap_data[0][a0] != 75 || cap_data[0][a1] != 0 ||
        cap_data[0][a2] != 0 || cap_data[0][a3] != -6)
      $display("FAIL decay_values got %0d %0d %0d %0d exp 75 0 0 -6", cap_data[0][a0],
               cap_data[0][a1], cap_data[0][a2], cap_data[0][a3]);
    else passed++;
    for (int a = 0; a < N; a++) begin
      checks++;
      if (cap_data[0][a] != model_b[a] || cap_cnt[0][a] != 1)
        $display("FAIL decay_map addr=%0d got=%0d cnt=%0d exp=%0d", a, cap_data[0][a],
                 cap_cnt[0][a], model_b[a]);
      else passed++;
    end
  endtask

  task automatic test_decay_drops();
    int t0;
    bit ok;
    sel = 1'b1; rst_b = 1'b1;
    tick(2);
    rst_b = 1'b0; t0 = cyc;
    for (int a = 0; a < N; a++) model_b[a] = 0;
    wait_cycle(t0 + 1100);
    checks++;
    if (busy_m !== 1'b1) $display("FAIL sweep_active got busy=%b exp=1", busy_m);
    else passed++;
    for (int i = 0; i < 20; i++)
      send_event($urandom_range(0, N - 1), 1'($urandom), 16'($urandom), i < 8);
    checks++;
    if (drop_m !== 16'd12) $display("FAIL drop_count got=%0d exp=12", drop_m);
    else passed++;
    wait_cycle(t0 + 1700);
    wait_idle(ok);
    checks++;
    if (!ok || drop_m !== 16'd12 || last_ts_m !== last_sent_ts)
      $display("FAIL drop_after got ok=%0d drop=%0d ts=%h exp drop=12 ts=%h", ok, drop_m,
               last_ts_m, last_sent_ts);
    else passed++;
    capture(256, 1'b0, -1);
    for (int a = 0; a < N; a++) begin
      checks++;
      if (cap_data[0][a] != model_b[a] || cap_cnt[0][a] != 1)
        $display("FAIL drop_map addr=%0d got=%0d cnt=%0d exp=%0d", a, cap_data[0][a],
                 cap_cnt[0][a], model_b[a]);
      else passed++;
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; sel = 1'b0;
    x_i = '0; y_i = '0; pol_i = 1'b0; ts_i = '0; ev_i = 1'b0;
    start_i = 1'b0; ready_i = 1'b0; last_sent_ts = '0;
    for (int a = 0; a < N; a++) begin model_a[a] = 0; model_b[a] = 0; end
    tick(1);
    test_reset();
    test_single_cell();
    test_saturation();
    test_back_to_back();
    test_random_events();
    test_readout_stall();
    test_decay_values();
    test_decay_drops();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got time=%0t exp completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
